alu_arbiter: RTL and testbench

- Shares one ALU instance (add/sub/mul/div datapath, 2-bit func, 2*WIDTH result plus overflow flag) between two requesters.
- Round-robin arbitration; valid/ready request handshake per requester.
- Holds the granted operands and func stable on the ALU inputs for the op's latency, then captures the result and overflow flag.
- Returns the captured result to the owning requester as a one-cycle response pulse.

---
 rtl/alu_pkg.sv | 17 +
 rtl/rr_arb2.sv | 17 +
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: function codes and FSM state encoding.
package alu_pkg;

  localparam int ALU_FUNC_W = 2;

  localparam logic [ALU_FUNC_W-1:0] FUNC_ADD = 2'b00;
  localparam logic [ALU_FUNC_W-1:0] FUNC_SUB = 2'b01;
  localparam logic [ALU_FUNC_W-1:0] FUNC_MUL = 2'b10;
  localparam logic [ALU_FUNC_W-1:0] FUNC_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins; on contention the pointer decides.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: round-robin accept, hold operands
// for the op latency, capture result/overflow, then pulse the owner's response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic [ALU_FUNC_W-1:0] req0_func,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  input  logic [ALU_FUNC_W-1:0] req1_func,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [ALU_FUNC_W-1:0] alu_func,
  input  logic [2*WIDTH-1:0]    alu_out,
  input  logic                  alu_ovf,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  rsp_ovf,
  output logic                  busy
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT)
                           ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                           : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
  localparam int CNT_W = $clog2(MAX_LAT) + 1;

  if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("alu_arbiter: ADD_LAT, MUL_LAT and DIV_LAT must all be >= 1");
  end

  function automatic logic [CNT_W-1:0] lat_m1(input logic [ALU_FUNC_W-1:0] f);
    case (f)
      FUNC_ADD, FUNC_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
      FUNC_MUL:           lat_m1 = CNT_W'(MUL_LAT - 1);
      default:            lat_m1 = CNT_W'(DIV_LAT - 1);
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    owner_q, owner_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [ALU_FUNC_W-1:0]   func_q, func_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      rsp_data_q, rsp_data_d;
  logic                    rsp_ovf_q, rsp_ovf_d;
  logic [1:0]              gnt;
  logic                    idle;

  rr_arb2 u_arb (
    .req ({req1_valid, req0_valid}),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign idle       = (state_q == ST_IDLE);
  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    func_d     = func_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          owner_d = gnt[1];
          a_d     = gnt[1] ? req1_a    : req0_a;
          b_d     = gnt[1] ? req1_b    : req0_b;
          func_d  = gnt[1] ? req1_func : req0_func;
          cnt_d   = lat_m1(gnt[1] ? req1_func : req0_func);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Sample on the last of the 'latency' hold cycles.
        if (cnt_q == '0) begin
          rsp_data_d = alu_out;
          rsp_ovf_d  = alu_ovf;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers are cleared too so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      func_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      func_q     <= func_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_func   = func_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
  assign rsp1_valid = (state_q == ST_RESP) && owner_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a latency-aware ALU model that returns garbage until held long enough.
module tb_alu_arbiter;

  localparam int W       = 6;
  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [1:0]     req0_func, req1_func;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_func;
  logic [2*W-1:0] alu_out;
  logic           alu_ovf;
  logic           rsp0_valid, rsp1_valid;
  logic [2*W-1:0] rsp_data;
  logic           rsp_ovf;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int held   = 0;
  logic           log_owner[$];
  logic [2*W-1:0] log_data[$];

  alu_arbiter #(.WIDTH(W), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_func(req0_func),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_func(req1_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out), .alu_ovf(alu_ovf),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model: counts how long inputs have been presented while busy; result is inverted until ready.
  always @(posedge clk) held <= busy ? held + 1 : 0;

  logic [2*W-1:0] m_res;
  logic           m_ovf;
  logic [W:0]     m_sum;
  logic [W-1:0]   m_dif;
  int             m_need;
  always_comb begin
    m_res  = '0;
    m_ovf  = 1'b0;
    m_sum  = '0;
    m_dif  = '0;
    m_need = ADD_LAT;
    case (alu_func)
      2'b00: begin
        m_sum = {1'b0, alu_a} + {1'b0, alu_b};
        m_res = {{W{1'b0}}, m_sum[W-1:0]};
        m_ovf = m_sum[W];
      end
      2'b01: begin
        m_dif = alu_a - alu_b;
        m_res = {{W{1'b0}}, m_dif};
        m_ovf = (alu_a < alu_b);
      end
      2'b10: begin
        m_res  = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
        m_need = MUL_LAT;
      end
      default: begin
        m_need = DIV_LAT;
        if (alu_b == '0) begin
          m_res = '1;
          m_ovf = 1'b1;
        end else begin
          m_dif = alu_a / alu_b;
          m_res = {{W{1'b0}}, m_dif};
        end
      end
    endcase
    alu_out = (held >= m_need - 1) ? m_res : ~m_res;
    alu_ovf = (held >= m_need - 1) ? m_ovf : ~m_ovf;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(rsp0_valid && rsp1_valid)) else begin
        errors++;
        $error("FAIL rsp_exclusive: observed rsp0=%0b rsp1=%0b expected not both", rsp0_valid, rsp1_valid);
      end
    end
    if (rsp0_valid || rsp1_valid) begin
      log_owner.push_back(rsp1_valid);
      log_data.push_back(rsp_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    log_owner.delete();
    log_data.delete();
  endtask

  task automatic drive0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
  endtask

  task automatic drive1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
  endtask

  initial begin
    int n;
    int saved;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_func = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_func = '0;
    cyc();
    cyc();
    check("rst_alu_in", 32'({alu_a, alu_b, alu_func}), 32'h0);
    check("rst_rsp", 32'({rsp_data, rsp_ovf, rsp0_valid, rsp1_valid}), 32'h0);
    check("rst_ctl", 32'({busy, req0_ready, req1_ready}), 32'h0);
    rst = 1'b0;

    // Test 1: single add
    drive0(6'd5, 6'd3, 2'b00);
    #1;
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    check("t1_exec_func", 32'(alu_func), 32'd0);
    check("t1_exec_ops", 32'({alu_a, alu_b}), 32'({6'd5, 6'd3}));
    check("t1_exec_rsp0", 32'(rsp0_valid), 32'd0);
    cyc();
    check("t1_rsp0", 32'(rsp0_valid), 32'd1);
    check("t1_data", 32'(rsp_data), 32'd8);
    check("t1_ovf", 32'(rsp_ovf), 32'd0);
    check("t1_rsp1", 32'(rsp1_valid), 32'd0);
    cyc();
    check("t1_after", 32'({rsp0_valid, busy}), 32'd0);

    // Test 2: contention after reset
    do_reset();
    drive0(6'd7, 6'd2, 2'b01);
    drive1(6'd3, 6'd4, 2'b10);
    #1;
    check("t2_ready0", 32'(req0_ready), 32'd1);
    check("t2_ready1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    check("t2_exec0_func", 32'(alu_func), 32'd1);
    cyc();
    check("t2_rsp0", 32'(rsp0_valid), 32'd1);
    check("t2_data0", 32'(rsp_data), 32'd5);
    check("t2_rsp_ready1", 32'(req1_ready), 32'd0);
    cyc();
    check("t2_ready1_idle", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      check("t2_mul_hold", 32'({alu_func, alu_a, alu_b}), 32'({2'b10, 6'd3, 6'd4}));
      check("t2_mul_norsp", 32'(rsp1_valid), 32'd0);
      cyc();
    end
    check("t2_rsp1", 32'(rsp1_valid), 32'd1);
    check("t2_data1", 32'(rsp_data), 32'd12);
    check("t2_rsp0_low", 32'(rsp0_valid), 32'd0);
    cyc();
    check("t2_count", 32'(log_owner.size()), 32'd2);
    if (log_owner.size() == 2) begin
      check("t2_order0", 32'(log_owner[0]), 32'd0);
      check("t2_order1", 32'(log_owner[1]), 32'd1);
    end

    // Test 3: continuous contention alternates
    do_reset();
    drive0(6'd1, 6'd2, 2'b00);
    drive1(6'd4, 6'd5, 2'b00);
    n = 0;
    while (log_owner.size() < 6 && n < 100) begin
      cyc();
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_done", 32'(log_owner.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < log_owner.size(); i++) begin
      check("t3_owner", 32'(log_owner[i]), 32'(i % 2));
      check("t3_data", 32'(log_data[i]), (i % 2 == 1) ? 32'd9 : 32'd3);
    end
    cyc();
    cyc();
    check("t3_idle", 32'(busy), 32'd0);

    // Test 4: lone divide
    do_reset();
    drive1(6'd12, 6'd4, 2'b11);
    #1;
    check("t4_ready1", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      check("t4_busy", 32'(busy), 32'd1);
      check("t4_hold", 32'({alu_func, alu_a, alu_b}), 32'({2'b11, 6'd12, 6'd4}));
      check("t4_norsp", 32'(rsp1_valid), 32'd0);
      cyc();
    end
    check("t4_busy_resp", 32'(busy), 32'd1);
    check("t4_rsp1", 32'(rsp1_valid), 32'd1);
    check("t4_data", 32'(rsp_data), 32'd3);
    cyc();
    check("t4_busy_end", 32'(busy), 32'd0);

    // Test 5: reset mid-divide
    do_reset();
    drive0(6'd2, 6'd2, 2'b00);
    cyc();
    req0_valid = 1'b0;
    cyc();
    cyc();
    check("t5_pre_data", 32'(rsp_data), 32'd4);
    drive1(6'd20, 6'd5, 2'b11);
    cyc();
    req1_valid = 1'b0;
    cyc();
    cyc();
    saved = log_owner.size();
    rst = 1'b1;
    cyc();
    check("t5_alu_zero", 32'({alu_a, alu_b, alu_func}), 32'h0);
    check("t5_rsp_zero", 32'({rsp_data, rsp_ovf, rsp0_valid, rsp1_valid}), 32'h0);
    check("t5_ctl_zero", 32'({busy, req0_ready, req1_ready}), 32'h0);
    rst = 1'b0;
    repeat (DIV_LAT + 2) cyc();
    check("t5_no_rsp", 32'(log_owner.size()), 32'(saved));
    drive0(6'd6, 6'd1, 2'b00);
    drive1(6'd2, 6'd9, 2'b00);
    #1;
    check("t5_ptr_ready0", 32'(req0_ready), 32'd1);
    check("t5_ptr_ready1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t5_exec_a", 32'(alu_a), 32'd6);
    cyc();
    check("t5_rsp0", 32'(rsp0_valid), 32'd1);
    check("t5_data", 32'(rsp_data), 32'd7);
    cyc();

    // Test 6: req0 waits while req1 is busy
    do_reset();
    drive1(6'd5, 6'd6, 2'b10);
    cyc();
    req1_valid = 1'b0;
    drive0(6'd9, 6'd4, 2'b01);
    for (int i = 0; i < MUL_LAT; i++) begin
      #1;
      check("t6_ready0_exec", 32'(req0_ready), 32'd0);
      check("t6_alu_a_exec", 32'(alu_a), 32'd5);
      cyc();
    end
    check("t6_ready0_resp", 32'(req0_ready), 32'd0);
    check("t6_rsp1", 32'(rsp1_valid), 32'd1);
    check("t6_data1", 32'(rsp_data), 32'd30);
    cyc();
    check("t6_ready0_idle", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    check("t6_ops", 32'({alu_func, alu_a, alu_b}), 32'({2'b01, 6'd9, 6'd4}));
    cyc();
    check("t6_rsp0", 32'(rsp0_valid), 32'd1);
    check("t6_data0", 32'(rsp_data), 32'd5);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
